// File: rtl/ripple_carry_adder_pkg.sv
// Shared constants for the ripple-carry adder block.
package ripple_carry_adder_pkg;

  localparam int unsigned ADDER_WIDTH_DEFAULT = 4;

endpackage

// File: rtl/full_adder.sv
// One-bit full-adder cell; the building block of the ripple chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/ripple_carry_adder.sv
// Unsigned ripple-carry adder with a registered result stage and valid tracking.
module ripple_carry_adder
  import ripple_carry_adder_pkg::*;
#(
  parameter int unsigned WIDTH = ADDER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             out_valid
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  // Result registers only load on a qualified sample; otherwise they hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum       <= '0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum   <= s;
        carry <= c[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Self-checking bench: WIDTH=4 (directed + exhaustive), WIDTH=1 and WIDTH=16 (random).
module tb_ripple_carry_adder;

  typedef struct packed {
    logic        v;
    logic [16:0] r;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;

  logic [3:0]  a4 = '0, b4 = '0, sum4;
  logic        cin4 = 1'b0, carry4, ov4;
  logic        a1 = 1'b0, b1 = 1'b0, sum1;
  logic        cin1 = 1'b0, carry1, ov1;
  logic [15:0] a16 = '0, b16 = '0, sum16;
  logic        cin16 = 1'b0, carry16, ov16;

  exp_t        q4[$], q1[$], q16[$];
  logic [16:0] last4 = '0, last1 = '0, last16 = '0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ripple_carry_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a4), .b(b4), .cin(cin4),
    .sum(sum4), .carry(carry4), .out_valid(ov4)
  );

  ripple_carry_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a1), .b(b1), .cin(cin1),
    .sum(sum1), .carry(carry1), .out_valid(ov1)
  );

  ripple_carry_adder #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a16), .b(b16), .cin(cin16),
    .sum(sum16), .carry(carry16), .out_valid(ov16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_4"},  32'({ov4, carry4, sum4}),    32'd0);
    check({tag, "_1"},  32'({ov1, carry1, sum1}),    32'd0);
    check({tag, "_16"}, 32'({ov16, carry16, sum16}), 32'd0);
  endtask

  // Drive one cycle: WIDTH=4 gets the given vector, the others get random operands.
  task automatic step(input logic v, input logic [3:0] x4, input logic [3:0] y4,
                      input logic c4);
    exp_t e;
    in_valid = v;
    a4 = x4; b4 = y4; cin4 = c4;
    a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
    a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
    if (v) begin
      last4  = 17'(x4) + 17'(y4) + 17'(c4);
      last1  = 17'(a1) + 17'(b1) + 17'(cin1);
      last16 = 17'(a16) + 17'(b16) + 17'(cin16);
    end
    e.v = v; e.r = last4;  q4.push_back(e);
    e.v = v; e.r = last1;  q1.push_back(e);
    e.v = v; e.r = last16; q16.push_back(e);
    @(posedge clk);
    #1;
    e = q4.pop_front();
    check("valid4", 32'(ov4), 32'(e.v));
    check("res4", 32'({carry4, sum4}), 32'(e.r));
    e = q1.pop_front();
    check("valid1", 32'(ov1), 32'(e.v));
    check("res1", 32'({carry1, sum1}), 32'(e.r));
    e = q16.pop_front();
    check("valid16", 32'(ov16), 32'(e.v));
    check("res16", 32'({carry16, sum16}), 32'(e.r));
  endtask

  initial begin
    logic [8:0] vec;
    // Reset asserted with random, qualified inputs.
    #1 rst = 1'b1;
    #1 check_zero("rst_async");
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
      a16 = 16'($urandom); b16 = 16'($urandom); a1 = 1'($urandom);
      @(posedge clk);
      #1 check_zero("rst_hold");
    end
    @(negedge clk);
    rst = 1'b0;

    step(1'b1, 4'b1011, 4'b0100, 1'b0);
    check("dir_1011_0100", 32'({ov4, carry4, sum4}), 32'b1_0_1111);
    step(1'b1, 4'b1111, 4'b1100, 1'b0);
    check("dir_1111_1100", 32'({ov4, carry4, sum4}), 32'b1_1_1011);
    step(1'b1, 4'b1001, 4'b0110, 1'b1);
    check("dir_full_ripple", 32'({ov4, carry4, sum4}), 32'b1_1_0000);
    step(1'b1, 4'b1111, 4'b1101, 1'b1);
    check("dir_1111_1101", 32'({ov4, carry4, sum4}), 32'b1_1_1101);
    step(1'b1, 4'b1011, 4'b1100, 1'b1);
    check("dir_1011_1100", 32'({ov4, carry4, sum4}), 32'b1_1_1000);
    step(1'b0, 4'b0001, 4'b0010, 1'b0);
    check("dir_hold", 32'({ov4, carry4, sum4}), 32'b0_1_1000);
    step(1'b1, 4'b1111, 4'b1111, 1'b1);
    check("dir_max", 32'({ov4, carry4, sum4}), 32'b1_1_1111);
    step(1'b1, 4'b1111, 4'b0000, 1'b1);
    check("dir_wrap", 32'({ov4, carry4, sum4}), 32'b1_1_0000);

    // Exhaustive WIDTH=4, back-to-back.
    for (int i = 0; i < 512; i++) begin
      vec = 9'(i);
      step(1'b1, vec[3:0], vec[7:4], vec[8]);
    end

    // Random valid pattern exercises hold behaviour on all widths.
    for (int i = 0; i < 100; i++) begin
      step(1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
    end

    // Mid-stream reset clears outputs without a clock edge and drops a same-cycle sample.
    step(1'b1, 4'b0111, 4'b0110, 1'b1);
    rst = 1'b1;
    #1 check_zero("rst_mid_async");
    in_valid = 1'b1;
    a4 = 4'b1010; b4 = 4'b0101; cin4 = 1'b1;
    @(posedge clk);
    #1 check_zero("rst_mid_drop");
    @(negedge clk);
    rst = 1'b0;
    last4 = '0; last1 = '0; last16 = '0;
    step(1'b0, 4'b1100, 4'b0011, 1'b0);
    step(1'b1, 4'b0101, 4'b0101, 1'b0);
    check("dir_after_rst", 32'({ov4, carry4, sum4}), 32'b1_0_1010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
